// File: rtl/fixed_divide_pipe.sv
`default_nettype none
// ============================================================================
// Module  : fixed_divide_pipe
// Brief   : Fully pipelined restoring fixed-point divider with tag sideband,
//           signed/unsigned modes, saturation and div-zero/overflow flags.
// Revision: 1.0 - initial release
// ============================================================================
module fixed_divide_pipe #(
   parameter int WIDTH     = 24,
   parameter int FRAC_BITS = 24,
   parameter int QWIDTH    = 26,
   parameter int SIGNED    = 0,
   parameter int TAG_WIDTH = 8
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 valid_in,
   input  logic [WIDTH-1:0]     dividend_in,
   input  logic [WIDTH-1:0]     divisor_in,
   input  logic [TAG_WIDTH-1:0] tag_in,
   output logic                 valid_out,
   output logic [QWIDTH-1:0]    quotient_out,
   output logic [TAG_WIDTH-1:0] tag_out,
   output logic                 div_zero_out,
   output logic                 overflow_out
);
   localparam int c_REM_W  = WIDTH + 1;
   localparam int c_NUM_W  = c_REM_W + QWIDTH;
   localparam int c_LIM_SH = (SIGNED != 0) ? QWIDTH - 1 : QWIDTH;
   localparam logic [QWIDTH-1:0] c_ALL_ONES = {QWIDTH{1'b1}};
   localparam logic [QWIDTH-1:0] c_MAX_POS  = {1'b0, {(QWIDTH-1){1'b1}}};
   localparam logic [QWIDTH-1:0] c_MIN_NEG  = {1'b1, {(QWIDTH-1){1'b0}}};

   // Raw input capture keeps every input path a single register deep.
   logic                 r_in_valid;
   logic [WIDTH-1:0]     r_in_a;
   logic [WIDTH-1:0]     r_in_b;
   logic [TAG_WIDTH-1:0] r_in_tag;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_in_valid <= 1'b0;
      end else begin
         r_in_valid <= valid_in;
      end
      r_in_a   <= dividend_in;
      r_in_b   <= divisor_in;
      r_in_tag <= tag_in;
   end

   logic               w_a_neg;
   logic               w_b_neg;
   logic               w_b_zero;
   logic [c_REM_W-1:0] w_mag_a;
   logic [c_REM_W-1:0] w_mag_b;
   logic [c_NUM_W-1:0] w_num;
   logic [c_NUM_W-1:0] w_lim;

   always_comb begin
      w_a_neg  = (SIGNED != 0) && r_in_a[WIDTH-1];
      w_b_neg  = (SIGNED != 0) && r_in_b[WIDTH-1];
      w_b_zero = (r_in_b == '0);
      w_mag_a  = w_a_neg ? -{1'b1, r_in_a} : {1'b0, r_in_a};
      w_mag_b  = w_b_neg ? -{1'b1, r_in_b} : {1'b0, r_in_b};
      w_num    = c_NUM_W'(w_mag_a) << FRAC_BITS;
      w_lim    = c_NUM_W'(w_mag_b) << c_LIM_SH;
   end

   // Index 0 is the operand stage; index k holds the state after quotient bit k.
   logic [QWIDTH:0]        r_valid;
   logic [QWIDTH:0]        r_neg;
   logic [QWIDTH:0]        r_dpos;
   logic [QWIDTH:0]        r_dz;
   logic [QWIDTH:0]        r_ovf;
   logic [TAG_WIDTH-1:0]   r_tag [0:QWIDTH];
   logic [QWIDTH-1:0]      r_nq  [0:QWIDTH];
   logic [c_REM_W-1:0]     r_rem [0:QWIDTH-1];
   logic [c_REM_W-1:0]     r_den [0:QWIDTH-1];

   logic [c_REM_W:0]       w_trial [1:QWIDTH];
   logic                   w_ge    [1:QWIDTH];
   logic [c_REM_W-1:0]     w_sub   [1:QWIDTH-1];

   // The remainder stays below the divisor, so the low bits of the difference suffice.
   always_comb begin
      for (int k = 1; k <= QWIDTH; k++) begin
         w_trial[k] = {r_rem[k-1], r_nq[k-1][QWIDTH-1]};
         w_ge[k]    = (w_trial[k] >= {1'b0, r_den[k-1]});
      end
      for (int k = 1; k < QWIDTH; k++) begin
         w_sub[k] = w_trial[k][c_REM_W-1:0] - r_den[k-1];
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_valid <= '0;
      end else begin
         r_valid <= {r_valid[QWIDTH-1:0], r_in_valid};
      end
      r_neg  <= {r_neg[QWIDTH-1:0], w_a_neg ^ w_b_neg};
      r_dpos <= {r_dpos[QWIDTH-1:0], ~w_a_neg};
      r_dz   <= {r_dz[QWIDTH-1:0], w_b_zero};
      r_ovf  <= {r_ovf[QWIDTH-1:0], ~w_b_zero & (w_num >= w_lim)};

      r_tag[0] <= r_in_tag;
      r_nq[0]  <= w_num[QWIDTH-1:0];
      r_rem[0] <= w_num[c_NUM_W-1:QWIDTH];
      r_den[0] <= w_mag_b;

      // Numerator bits shift out of the MSB while quotient bits shift into the LSB.
      for (int k = 1; k <= QWIDTH; k++) begin
         r_tag[k] <= r_tag[k-1];
         r_nq[k]  <= {r_nq[k-1][QWIDTH-2:0], w_ge[k]};
      end
      for (int k = 1; k < QWIDTH; k++) begin
         r_rem[k] <= w_ge[k] ? w_sub[k] : w_trial[k][c_REM_W-1:0];
         r_den[k] <= r_den[k-1];
      end
   end

   logic [QWIDTH-1:0] w_q_sel;

   always_comb begin
      w_q_sel = r_nq[QWIDTH];
      if (r_dz[QWIDTH]) begin
         if (SIGNED == 0) w_q_sel = c_ALL_ONES;
         else             w_q_sel = r_dpos[QWIDTH] ? c_MAX_POS : c_MIN_NEG;
      end else if (r_ovf[QWIDTH]) begin
         if (SIGNED == 0) w_q_sel = c_ALL_ONES;
         else             w_q_sel = r_neg[QWIDTH] ? c_MIN_NEG : c_MAX_POS;
      end else if (r_neg[QWIDTH]) begin
         w_q_sel = -r_nq[QWIDTH];
      end
   end

   logic                 r_valid_out;
   logic [QWIDTH-1:0]    r_quotient;
   logic [TAG_WIDTH-1:0] r_tag_out;
   logic                 r_dz_out;
   logic                 r_ovf_out;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_valid_out <= 1'b0;
         r_quotient  <= '0;
         r_tag_out   <= '0;
         r_dz_out    <= 1'b0;
         r_ovf_out   <= 1'b0;
      end else begin
         r_valid_out <= r_valid[QWIDTH];
         if (r_valid[QWIDTH]) begin
            r_quotient <= w_q_sel;
            r_tag_out  <= r_tag[QWIDTH];
            r_dz_out   <= r_dz[QWIDTH];
            r_ovf_out  <= r_ovf[QWIDTH];
         end
      end
   end

   assign valid_out    = r_valid_out;
   assign quotient_out = r_quotient;
   assign tag_out      = r_tag_out;
   assign div_zero_out = r_dz_out;
   assign overflow_out = r_ovf_out;

endmodule
`default_nettype wire

// File: tb/tb_fixed_divide_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_fixed_divide_pipe
// Brief   : Self-checking bench for fixed_divide_pipe, unsigned and signed.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fixed_divide_pipe;
   localparam int c_W   = 24;
   localparam int c_F   = 24;
   localparam int c_Q   = 26;
   localparam int c_T   = 8;
   localparam int c_LAT = c_Q + 2;
   localparam logic [c_Q-1:0] c_ONES = {c_Q{1'b1}};
   localparam logic [c_Q-1:0] c_MAXP = {1'b0, {(c_Q-1){1'b1}}};
   localparam logic [c_Q-1:0] c_MINN = {1'b1, {(c_Q-1){1'b0}}};

   typedef struct {
      bit             sgn;
      logic [c_W-1:0] a;
      logic [c_W-1:0] b;
      logic [c_T-1:0] tag;
      logic [c_Q-1:0] q;
      bit             dz;
      bit             ovf;
   } vec_t;

   typedef struct {
      int                 due;
      logic [c_Q+c_T+1:0] res;
   } sb_t;

   logic           clk;
   logic           rst;
   logic           valid_in;
   logic [c_W-1:0] dividend;
   logic [c_W-1:0] divisor;
   logic [c_T-1:0] tag_in;
   logic           u_valid, s_valid;
   logic [c_Q-1:0] u_q, s_q;
   logic [c_T-1:0] u_tag, s_tag;
   logic           u_dz, s_dz, u_ovf, s_ovf;

   int  checks = 0;
   int  errors = 0;
   int  ncyc   = 0;
   bit  sb_on  = 0;
   sb_t exp_u [$];
   sb_t exp_s [$];

   fixed_divide_pipe #(.WIDTH(c_W), .FRAC_BITS(c_F), .QWIDTH(c_Q), .SIGNED(0), .TAG_WIDTH(c_T)) u_dut_u (
      .clk_in(clk), .rst_in(rst), .valid_in(valid_in), .dividend_in(dividend),
      .divisor_in(divisor), .tag_in(tag_in), .valid_out(u_valid), .quotient_out(u_q),
      .tag_out(u_tag), .div_zero_out(u_dz), .overflow_out(u_ovf));

   fixed_divide_pipe #(.WIDTH(c_W), .FRAC_BITS(c_F), .QWIDTH(c_Q), .SIGNED(1), .TAG_WIDTH(c_T)) u_dut_s (
      .clk_in(clk), .rst_in(rst), .valid_in(valid_in), .dividend_in(dividend),
      .divisor_in(divisor), .tag_in(tag_in), .valid_out(s_valid), .quotient_out(s_q),
      .tag_out(s_tag), .div_zero_out(s_dz), .overflow_out(s_ovf));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: exact integer quotient, truncated toward zero, then range-checked.
   function automatic logic [c_Q+c_T+1:0] model(input bit sgn, input logic [c_W-1:0] a,
                                                 input logic [c_W-1:0] b, input logic [c_T-1:0] t);
      longint sa, sb, qq, lim;
      logic [c_Q-1:0] q;
      bit dz, ovf;
      dz = 0;
      ovf = 0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'(a);
         sb = longint'(b);
      end
      if (sb == 0) begin
         dz = 1;
         if (!sgn) q = c_ONES;
         else      q = (sa >= 0) ? c_MAXP : c_MINN;
      end else begin
         qq  = (sa * (longint'(1) << c_F)) / sb;
         lim = sgn ? (longint'(1) << (c_Q - 1)) : (longint'(1) << c_Q);
         ovf = (qq >= lim) || (qq <= -lim);
         if (ovf) q = (!sgn) ? c_ONES : ((qq < 0) ? c_MINN : c_MAXP);
         else     q = qq[c_Q-1:0];
      end
      return {dz, ovf, t, q};
   endfunction

   function automatic logic [c_Q+c_T+1:0] got_res(input bit sgn);
      return sgn ? {s_dz, s_ovf, s_tag, s_q} : {u_dz, u_ovf, u_tag, u_q};
   endfunction

   function automatic bit got_valid(input bit sgn);
      return sgn ? s_valid : u_valid;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, ncyc);
      end
   endtask

   task automatic sb_port(input bit sgn);
      sb_t   e;
      bit    v, have;
      string p;
      p    = sgn ? "s_" : "u_";
      v    = got_valid(sgn);
      have = sgn ? (exp_s.size() != 0) : (exp_u.size() != 0);
      if (have) e = sgn ? exp_s[0] : exp_u[0];
      if (v && !have) begin
         chk({p, "spurious_valid"}, v, 1'b0);
      end else if (v || (have && e.due <= ncyc)) begin
         if (sgn) e = exp_s.pop_front();
         else     e = exp_u.pop_front();
         chk({p, "sb_latency"}, ncyc, e.due);
         chk({p, "sb_valid"}, v, 1'b1);
         if (v) chk({p, "sb_result"}, got_res(sgn), e.res);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      ncyc++;
      if (sb_on) begin
         sb_port(1'b0);
         sb_port(1'b1);
      end
   endtask

   task automatic run_one(input vec_t v, input string name);
      int iss;
      bit got;
      valid_in = 1'b1;
      dividend = v.a;
      divisor  = v.b;
      tag_in   = v.tag;
      iss      = ncyc;
      tick();
      valid_in = 1'b0;
      got      = 0;
      for (int i = 0; i < c_LAT + 6 && !got; i++) begin
         if (got_valid(v.sgn)) got = 1;
         else tick();
      end
      chk({name, "_arrived"}, got, 1'b1);
      if (got) begin
         chk({name, "_latency"}, ncyc - iss, c_LAT + 1);
         chk({name, "_result"}, got_res(v.sgn), {v.dz, v.ovf, v.tag, v.q});
      end
   endtask

   task automatic throughput();
      bit             op_v [5];
      logic [c_W-1:0] ta [5];
      logic [c_W-1:0] tb [5];
      logic [c_T-1:0] tt [5];
      logic [c_Q-1:0] eq [5];
      int iss;
      op_v = '{1, 1, 1, 0, 1};
      ta   = '{24'h400000, 24'h100000, 24'h000003, 24'h777777, 24'h300000};
      tb   = '{24'h800000, 24'h400000, 24'h000001, 24'h000001, 24'h600000};
      tt   = '{8'h01, 8'h02, 8'h03, 8'hEE, 8'h04};
      eq   = '{26'h0800000, 26'h0400000, 26'h3000000, 26'h0, 26'h0800000};
      iss  = ncyc;
      for (int i = 0; i < 5; i++) begin
         valid_in = op_v[i];
         dividend = ta[i];
         divisor  = tb[i];
         tag_in   = tt[i];
         tick();
      end
      valid_in = 1'b0;
      while (ncyc < iss + c_LAT) tick();
      chk("tp_early_valid", u_valid, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("tp_valid%0d", i), u_valid, op_v[i]);
         if (op_v[i]) chk($sformatf("tp_result%0d", i), got_res(1'b0), {2'b00, tt[i], eq[i]});
         else         chk("tp_bubble_hold", got_res(1'b0), {2'b00, tt[2], eq[2]});
      end
   endtask

   task automatic reset_midflight();
      int   seen;
      vec_t pv;
      for (int i = 0; i < 5; i++) begin
         valid_in = 1'b1;
         dividend = 24'($urandom());
         divisor  = 24'($urandom_range(1, 24'hFFFFFF));
         tag_in   = 8'(8'h40 + i);
         tick();
      end
      valid_in = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_u_outputs", {u_valid, got_res(1'b0)}, '0);
      chk("rst_s_outputs", {s_valid, got_res(1'b1)}, '0);
      seen = 0;
      repeat (c_LAT + 8) begin
         tick();
         if (u_valid || s_valid) seen++;
      end
      chk("rst_dropped_ops", seen, 0);
      pv = '{0, 24'h400000, 24'h800000, 8'h55, 26'h0800000, 0, 0};
      run_one(pv, "post_rst_u");
      pv = '{1, 24'hE00000, 24'h400000, 8'h56, 26'h3800000, 0, 0};
      run_one(pv, "post_rst_s");
   endtask

   task automatic random_stream();
      sb_t            e;
      bit             v;
      logic [c_W-1:0] a, b;
      logic [c_T-1:0] t;
      sb_on = 1;
      for (int n = 0; n < 1000; n++) begin
         v = ($urandom_range(0, 9) < 8);
         a = 24'($urandom());
         b = 24'($urandom());
         t = 8'($urandom());
         case ($urandom_range(0, 7))
            0: b = '0;
            1: b = 24'($urandom_range(1, 15));
            2: a = '0;
            3: a = 24'h800000;
            4: b = 24'h800000;
            5: a = 24'($urandom_range(0, 255));
            default: ;
         endcase
         if (v) begin
            e.due = ncyc + 1 + c_LAT;
            e.res = model(1'b0, a, b, t);
            exp_u.push_back(e);
            e.res = model(1'b1, a, b, t);
            exp_s.push_back(e);
         end
         valid_in = v;
         dividend = a;
         divisor  = b;
         tag_in   = t;
         tick();
      end
      valid_in = 1'b0;
      repeat (c_LAT + 4) tick();
      chk("u_drain_empty", exp_u.size(), 0);
      chk("s_drain_empty", exp_s.size(), 0);
      sb_on = 0;
   endtask

   initial begin
      vec_t vecs [18];
      vecs[0]  = '{0, 24'h400000, 24'h800000, 8'h11, 26'h0800000, 0, 0};
      vecs[1]  = '{0, 24'h000003, 24'h000001, 8'h12, 26'h3000000, 0, 0};
      vecs[2]  = '{0, 24'hFFFFFF, 24'h000001, 8'h13, 26'h3FFFFFF, 0, 1};
      vecs[3]  = '{0, 24'h123456, 24'h000000, 8'h14, 26'h3FFFFFF, 1, 0};
      vecs[4]  = '{0, 24'h000000, 24'h000005, 8'h15, 26'h0000000, 0, 0};
      vecs[5]  = '{0, 24'h000001, 24'hFFFFFF, 8'h16, 26'h0000001, 0, 0};
      vecs[6]  = '{0, 24'h000004, 24'h000001, 8'h17, 26'h3FFFFFF, 0, 1};
      vecs[7]  = '{1, 24'hE00000, 24'h400000, 8'h21, 26'h3800000, 0, 0};
      vecs[8]  = '{1, 24'h7FFFFF, 24'h000001, 8'h22, 26'h1FFFFFF, 0, 1};
      vecs[9]  = '{1, 24'h800000, 24'h000000, 8'h23, 26'h2000000, 1, 0};
      vecs[10] = '{1, 24'h000000, 24'h000000, 8'h24, 26'h1FFFFFF, 1, 0};
      vecs[11] = '{1, 24'h200000, 24'hC00000, 8'h25, 26'h3800000, 0, 0};
      vecs[12] = '{1, 24'h800000, 24'h000001, 8'h26, 26'h2000000, 0, 1};
      vecs[13] = '{1, 24'hFFFFFF, 24'h000003, 8'h27, 26'h3AAAAAB, 0, 0};
      vecs[14] = '{1, 24'h000000, 24'hFFFFFF, 8'h28, 26'h0000000, 0, 0};
      vecs[15] = '{1, 24'h000002, 24'h000001, 8'h29, 26'h1FFFFFF, 0, 1};
      vecs[16] = '{1, 24'h000001, 24'h000001, 8'h2A, 26'h1000000, 0, 0};
      vecs[17] = '{1, 24'hFFFFFF, 24'h000001, 8'h2B, 26'h3000000, 0, 0};

      rst      = 1'b1;
      valid_in = 1'b0;
      dividend = '0;
      divisor  = '0;
      tag_in   = '0;
      repeat (3) tick();
      chk("reset_u_outputs", {u_valid, got_res(1'b0)}, '0);
      chk("reset_s_outputs", {s_valid, got_res(1'b1)}, '0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 18; i++) run_one(vecs[i], $sformatf("vec%0d", i));
      throughput();
      reset_midflight();
      random_stream();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
